// File: rtl/brightness_scaler_if.sv
// Pixel stream plus frame-setting bus for brightness_scaler.
// slave = the scaler's view; master = source/sink driving it.
interface brightness_scaler_if #(
  parameter int CH_W   = 4,
  parameter int NUM_CH = 3
);
  logic [1:0]             freq_flag;
  logic                   use_flag;
  logic [NUM_CH*CH_W-1:0] data_in;
  logic                   sop_in;
  logic                   eop_in;
  logic                   valid_in;
  logic                   ready_in;
  logic                   ready_out;
  logic [NUM_CH*CH_W-1:0] data_out;
  logic                   sop_out;
  logic                   eop_out;
  logic                   valid_out;

  modport slave (
    input  freq_flag, use_flag, data_in, sop_in, eop_in, valid_in, ready_in,
    output ready_out, data_out, sop_out, eop_out, valid_out
  );

  modport master (
    output freq_flag, use_flag, data_in, sop_in, eop_in, valid_in, ready_in,
    input  ready_out, data_out, sop_out, eop_out, valid_out
  );
endinterface

// File: rtl/brightness_scaler.sv
// Two-stage per-channel fixed-point gain with saturation, settings latched per frame.
// Optional per-frame clip counter enabled by defining BRI_CLIP_COUNT_EN.
module brightness_scaler #(
  parameter int CH_W      = 4,
  parameter int NUM_CH    = 3,
  parameter int GAIN_W    = 4,
  parameter int GAIN_FRAC = 2,
  parameter int GAIN0     = 4,
  parameter int GAIN1     = 8,
  parameter int GAIN2     = 12,
  parameter int GAIN3     = 2
) (
  input  logic              clk,
  input  logic              reset,
  brightness_scaler_if.slave bus
`ifdef BRI_CLIP_COUNT_EN
  ,
  output logic [15:0]       clip_count
`endif
);
  localparam int PIX_W  = NUM_CH * CH_W;
  localparam int PROD_W = CH_W + GAIN_W;
  localparam logic [PROD_W-1:0] CH_MAX = PROD_W'((1 << CH_W) - 1);

  logic [1:0]        sel_q;
  logic              use_q;
  logic [1:0]        sel_eff;
  logic              use_eff;
  logic [GAIN_W-1:0] gain;
  logic              advance;
  logic              accept;

  logic                           s1_valid;
  logic                           s1_sop;
  logic                           s1_eop;
  logic                           s1_use;
  logic [PIX_W-1:0]               s1_raw;
  logic [NUM_CH-1:0][PROD_W-1:0]  s1_prod;
  logic [NUM_CH-1:0][PROD_W-1:0]  prod_c;
  logic [PIX_W-1:0]               s2_data;
  logic [NUM_CH-1:0]              sat_c;

  // The whole pipeline moves together whenever the output slot is free.
  assign bus.ready_out = !bus.valid_out || bus.ready_in;
  assign advance       = bus.ready_out;
  assign accept        = bus.valid_in && advance;

  // The SOP beat itself already uses the freshly presented settings.
  always_comb begin
    sel_eff = (accept && bus.sop_in) ? bus.freq_flag : sel_q;
    use_eff = (accept && bus.sop_in) ? bus.use_flag  : use_q;
    case (sel_eff)
      2'd0:    gain = GAIN_W'(GAIN0);
      2'd1:    gain = GAIN_W'(GAIN1);
      2'd2:    gain = GAIN_W'(GAIN2);
      default: gain = GAIN_W'(GAIN3);
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      prod_c[c] = PROD_W'(bus.data_in[c*CH_W +: CH_W]) * PROD_W'(gain);
    end
  end

  always_comb begin : stage2_comb
    logic [PROD_W-1:0] q;
    q       = '0;
    s2_data = '0;
    sat_c   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      q        = s1_prod[c] >> GAIN_FRAC;
      sat_c[c] = (q > CH_MAX);
      s2_data[c*CH_W +: CH_W] = sat_c[c] ? {CH_W{1'b1}} : q[CH_W-1:0];
    end
    if (!s1_use) begin
      s2_data = s1_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q         <= 2'd0;
      use_q         <= 1'b1;
      s1_valid      <= 1'b0;
      s1_sop        <= 1'b0;
      s1_eop        <= 1'b0;
      s1_use        <= 1'b1;
      s1_raw        <= '0;
      s1_prod       <= '0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.sop_out   <= 1'b0;
      bus.eop_out   <= 1'b0;
    end else begin
      if (accept && bus.sop_in) begin
        sel_q <= bus.freq_flag;
        use_q <= bus.use_flag;
      end
      if (advance) begin
        s1_valid      <= bus.valid_in;
        s1_sop        <= bus.valid_in && bus.sop_in;
        s1_eop        <= bus.valid_in && bus.eop_in;
        s1_use        <= use_eff;
        s1_raw        <= bus.data_in;
        s1_prod       <= prod_c;
        bus.valid_out <= s1_valid;
        bus.data_out  <= s2_data;
        bus.sop_out   <= s1_valid && s1_sop;
        bus.eop_out   <= s1_valid && s1_eop;
      end
    end
  end

`ifdef BRI_CLIP_COUNT_EN
  logic        clip_q;
  logic [15:0] clip_acc;
  logic [15:0] clip_total;

  always_comb begin
    clip_total = (clip_q && clip_acc != 16'hFFFF) ? clip_acc + 16'd1 : clip_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_q     <= 1'b0;
      clip_acc   <= 16'd0;
      clip_count <= 16'd0;
    end else begin
      if (advance) begin
        clip_q <= s1_valid && s1_use && (|sat_c);
      end
      if (bus.valid_out && bus.ready_in) begin
        if (bus.eop_out) begin
          clip_count <= clip_total;
          clip_acc   <= 16'd0;
        end else begin
          clip_acc   <= clip_total;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_brightness_scaler.sv
// Randomised and directed bench for brightness_scaler against a frame-level model.
// Define BRI_CLIP_COUNT_EN to also check the per-frame clip counter.
module tb_brightness_scaler;
  localparam int CH_W   = 4;
  localparam int NUM_CH = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  brightness_scaler_if #(.CH_W(CH_W), .NUM_CH(NUM_CH)) bus ();
`ifdef BRI_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  brightness_scaler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BRI_CLIP_COUNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: gain in quarter units, result = floor(ch*gain/4) capped at 15.
  typedef struct {
    logic [11:0] data;
    bit          sop;
    bit          eop;
    bit          clip;
  } beat_t;

  beat_t exp_q[$];
  int    gain_q4[4] = '{4, 8, 12, 2};
  int    m_sel = 0;
  bit    m_use = 1'b1;

  function automatic beat_t model(input logic [11:0] px, input bit s, input bit e,
                                  input int sel, input bit use_it);
    beat_t b;
    int    v;
    b.data = px;
    b.sop  = s;
    b.eop  = e;
    b.clip = 1'b0;
    if (use_it) begin
      for (int c = 0; c < 3; c++) begin
        v = int'(px[c*4 +: 4]) * gain_q4[sel] / 4;
        if (v > 15) begin
          v      = 15;
          b.clip = 1'b1;
        end
        b.data[c*4 +: 4] = 4'(v);
      end
    end
    return b;
  endfunction

  bit          prev_stall = 1'b0;
  logic [14:0] prev_out   = '0;
  int          n_sop = 0;
  int          n_eop = 0;
  logic [11:0] last_data = '0;
  int          cc_acc = 0;
  int          cc_exp = 0;
  bit          cc_pending = 1'b0;
  bit          rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    bus.ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      exp_q.delete();
      m_sel      = 0;
      m_use      = 1'b1;
      cc_acc     = 0;
      cc_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.valid_out, bus.sop_out, bus.eop_out, bus.data_out}, prev_out);
`ifdef BRI_CLIP_COUNT_EN
      if (cc_pending) begin
        check("clip_count_eop", clip_count, cc_exp);
        cc_pending = 1'b0;
      end
`endif
      if (bus.valid_in && bus.ready_out) begin
        if (bus.sop_in) begin
          m_sel = int'(bus.freq_flag);
          m_use = bus.use_flag;
        end
        exp_q.push_back(model(bus.data_in, bus.sop_in, bus.eop_in, m_sel, m_use));
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {bus.sop_out, bus.eop_out, bus.data_out}, {e.sop, e.eop, e.data});
          if (e.clip && cc_acc < 16'hFFFF) cc_acc++;
          if (bus.eop_out) begin
            cc_exp     = cc_acc;
            cc_acc     = 0;
            cc_pending = 1'b1;
          end
        end
        n_sop    += int'(bus.sop_out);
        n_eop    += int'(bus.eop_out);
        last_data = bus.data_out;
      end
      prev_stall = bus.valid_out && !bus.ready_in;
      prev_out   = {bus.valid_out, bus.sop_out, bus.eop_out, bus.data_out};
    end
  end

  task automatic send(input logic [11:0] d, input bit s, input bit e,
                      input logic [1:0] ff, input bit uf);
    int t = 0;
    bus.data_in   = d;
    bus.sop_in    = s;
    bus.eop_in    = e;
    bus.freq_flag = ff;
    bus.use_flag  = uf;
    bus.valid_in  = 1'b1;
    @(negedge clk);
    while (!bus.ready_out && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  logic [11:0] exp14[4] = '{12'h14E, 12'h28F, 12'h3CF, 12'h027};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_in   = '0;
    bus.sop_in    = 1'b0;
    bus.eop_in    = 1'b0;
    bus.valid_in  = 1'b0;
    bus.freq_flag = 2'd0;
    bus.use_flag  = 1'b1;
    bus.ready_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.valid_out, 0);
    check("rst_data",  bus.data_out, 0);
    check("rst_sop",   bus.sop_out, 0);
    check("rst_eop",   bus.eop_out, 0);
`ifdef BRI_CLIP_COUNT_EN
    check("rst_clip_count", clip_count, 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Unity gain with exact two-cycle latency.
    send(12'h18E, 1, 0, 2'd0, 1);
    check("lat_cycle1_valid", bus.valid_out, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", bus.valid_out, 1);
    check("lat_cycle2_data", bus.data_out, 12'h18E);
    check("lat_cycle2_sop", bus.sop_out, 1);
    send(12'h18E, 0, 1, 2'd0, 1);
    drain();

    for (int f = 1; f < 4; f++) begin
      send(12'h14E, 1, 1, 2'(f), 1);
      drain();
      check($sformatf("gain_sel%0d", f), last_data, exp14[f]);
    end

    // Mid-frame gain change ignored; next SOP picks it up.
    send(12'h14E, 1, 0, 2'd1, 1);
    send(12'h14E, 0, 0, 2'd2, 1);
    send(12'h14E, 0, 1, 2'd2, 1);
    drain();
    check("midframe_ff_ignored", last_data, 12'h28F);
    send(12'h14E, 1, 1, 2'd2, 1);
    drain();
    check("next_frame_ff", last_data, 12'h3CF);

    // Bypass frame; mid-frame use toggle ignored.
    send(12'h14E, 1, 0, 2'd2, 0);
    send(12'h14E, 0, 1, 2'd2, 1);
    drain();
    check("bypass_toggle_ignored", last_data, 12'h14E);

    // Random 64-beat frame with backpressure and gaps.
    rand_ready = 1'b1;
    n_sop = 0;
    n_eop = 0;
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(12'($urandom), i == 0, i == 63, 2'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    drain();
    rand_ready = 1'b0;
    check("rand_sop_count", n_sop, 1);
    check("rand_eop_count", n_eop, 1);
    check("rand_queue_empty", exp_q.size(), 0);

    // Reset with two beats in flight, then a beat without SOP.
    send(12'h1A5, 1, 0, 2'd1, 1);
    send(12'h0F3, 0, 0, 2'd1, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_flush_valid", bus.valid_out, 0);
    send(12'h1A5, 0, 1, 2'd1, 1);
    drain();
    check("post_reset_unity", last_data, 12'h1A5);

    // Ten-beat frame, three saturating beats; then a clean frame.
    for (int i = 0; i < 10; i++) begin
      send((i == 2 || i == 5 || i == 7) ? 12'h008 : 12'h333, i == 0, i == 9, 2'd1, 1);
    end
    drain();
`ifdef BRI_CLIP_COUNT_EN
    check("clip_frame_three", clip_count, 3);
`endif
    for (int i = 0; i < 4; i++) begin
      send(12'h111, i == 0, i == 3, 2'd1, 1);
    end
    drain();
    check("clean_frame_data", last_data, 12'h222);
`ifdef BRI_CLIP_COUNT_EN
    check("clip_frame_zero", clip_count, 0);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/brightness_scaler.md
Name: brightness_scaler

Overview:
- Parametrised next-generation brightness stage for the pixel stream between the camera/frame path and the VGA output.
- Scales each of NUM_CH colour channels by a selectable fixed-point gain, with per-channel saturation.
- Registered 2-stage pipeline with full ready/valid backpressure.
- Gain and enable settings are latched at start-of-packet, so the setting never changes mid-frame.

Parameters:
- CH_W, 4: bits per colour channel.
- NUM_CH, 3: channels per pixel; channel 0 occupies the LSBs.
- GAIN_W, 4: gain word width, unsigned fixed point.
- GAIN_FRAC, 2: fractional bits of the gain word.
- GAIN0, 4: gain for freq_flag=0 (1.0).
- GAIN1, 8: gain for freq_flag=1 (2.0).
- GAIN2, 12: gain for freq_flag=2 (3.0).
- GAIN3, 2: gain for freq_flag=3 (0.5).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- freq_flag  in  2  gain select; sampled only on the accepted SOP beat
- use_flag  in  1  1 = scale, 0 = bypass; sampled only on the accepted SOP beat
- data_in  in  NUM_CH*CH_W  input pixel
- sop_in  in  1  start of packet
- eop_in  in  1  end of packet
- valid_in  in  1  input beat valid
- ready_in  in  1  downstream ready
- ready_out  out  1  this block can accept a beat
- data_out  out  NUM_CH*CH_W  scaled pixel
- sop_out  out  1  start of packet, delayed with its beat
- eop_out  out  1  end of packet, delayed with its beat
- valid_out  out  1  output beat valid
- clip_count  out  16  present only with BRI_CLIP_COUNT_EN

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - valid_out=0, data_out=0, sop_out=0, eop_out=0.
  - Both pipeline stages empty.
  - Latched gain select = 0; latched use = 1.
  - clip_count=0.
- Handshake:
  - Input beat is accepted when valid_in && ready_out.
  - Output beat is transferred when valid_out && ready_in.
  - ready_out = !valid_out || ready_in. This is a combinational path from ready_in.
  - When ready_out=1, the whole pipeline advances one stage.
  - When valid_out && !ready_in, data_out, sop_out, eop_out and valid_out hold stable.
- Latency:
  - 2 cycles from an accepted beat to valid_out when there is no stall.
  - Throughput is 1 beat per cycle.
  - valid_in=0 inserts a bubble; the stage valid bit is cleared and no data is dropped.
- Frame latch:
  - On an accepted beat with sop_in=1, freq_flag and use_flag are captured.
  - The captured values apply to that beat and to every beat until the next accepted SOP.
  - Changes to freq_flag or use_flag mid-frame have no effect.
  - Beats before the first SOP after reset use the reset values (gain select 0, use 1).
- Stage 1:
  - Per channel: prod = ch * GAINsel, width CH_W+GAIN_W.
  - sop, eop and use travel with the beat.
- Stage 2:
  - Per channel: q = prod >> GAIN_FRAC, truncated (floor).
  - If q > 2^CH_W-1, output 2^CH_W-1 and set the per-beat clip flag.
  - If use=0, data_out equals the input pixel unchanged and the clip flag is 0.
- sop/eop are never generated, merged or dropped; they pass through with their beat.
- Reset mid-frame: the pipeline is flushed and in-flight beats are discarded. The next frame must begin with SOP; beats before it use the reset gain.

Optional Feature:
- Macro: BRI_CLIP_COUNT_EN.
- With the macro defined:
  - clip_count port exists.
  - An internal 16-bit counter increments on each transferred output beat with the clip flag set; it saturates at 0xFFFF.
  - On transfer of a beat with eop_out=1, clip_count is loaded with the final total (including that beat) and the internal counter clears.
  - clip_count holds its value until the next EOP transfer or reset.
- Without the macro: no clip_count port and no counter logic; saturation behaviour is unchanged.

Test Plan:
- SOP beat with freq_flag=0, use=1, data 12'h18E, ready_in=1 -> data_out 12'h18E exactly 2 cycles later, with sop_out=1 on that beat.
- New frame with freq_flag=1, data 12'h14E -> 12'h28F (channel 14 saturated to 15). With freq_flag=2 -> 12'h3CF. With freq_flag=3 -> 12'h027.
- freq_flag switched 1->2 mid-frame -> remaining beats of the frame still use gain 2.0. The next SOP frame uses 3.0.
- Frame with use_flag=0, freq_flag=2, data 12'h14E -> 12'h14E passed through. A use_flag toggle mid-frame is ignored.
- Random ready_in (75% high) plus valid_in gaps over a 64-beat frame:
  - output sequence equals the model, with no loss or duplication;
  - outputs stay stable while stalled;
  - exactly one sop_out and one eop_out.
- Reset asserted for 1 cycle with 2 beats in flight -> valid_out=0 the next cycle. Post-reset beats without SOP use unity gain.
- With BRI_CLIP_COUNT_EN, frame of 10 beats, 3 of them saturating -> clip_count=3 after the EOP transfer. A following frame with no clipping -> clip_count=0.
